// File: rtl/serial_slave_port.sv
// Slave endpoint of the 1-bit serial bus: deserialises address/burst/write data,
// accesses a local word memory, and serialises read data back with a split (hold) window.
module serial_slave_port #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BURST_WIDTH  = 4,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic address_in,
    input  logic data_in,
    input  logic valid_in,
    input  logic write_en,
    input  logic burst,
    input  logic bus_ready,
    output logic data_out,
    output logic valid_out,
    output logic ready,
    output logic hold
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned MAX_W  = (MAX_AD > BURST_WIDTH) ? MAX_AD : BURST_WIDTH;
    localparam int unsigned CNT_W  = $clog2(MAX_W + 1);
    localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] BLEN_LAST = CNT_W'(BURST_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StBlen,
        StWdata,
        StRwait,
        StRdata
    } state_t;

    state_t                 state;
    logic                   is_write;
    logic                   is_burst;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [BURST_WIDTH-1:0] words_left;
    logic [CNT_W-1:0]       bit_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [DATA_WIDTH-1:0]  shreg;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic                   capture;
    logic [ADDR_WIDTH-1:0]  addr_shift;
    logic [ADDR_WIDTH-1:0]  addr_inc;
    logic [BURST_WIDTH-1:0] words_shift;
    logic [DATA_WIDTH-1:0]  data_shift;
    logic                   mem_we;

    always_comb begin
        capture     = valid_in && bus_ready;
        addr_shift  = (addr << 1) | ADDR_WIDTH'(address_in);
        addr_inc    = addr + ADDR_WIDTH'(1);
        words_shift = (words_left << 1) | BURST_WIDTH'(address_in);
        data_shift  = (shreg << 1) | DATA_WIDTH'(data_in);
        // A word is committed only on the edge that captures its final bit.
        mem_we      = !reset && (state == StWdata) && capture && (bit_cnt == DATA_LAST);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= data_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            ready      <= 1'b1;
            hold       <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= 1'b0;
            is_write   <= 1'b0;
            is_burst   <= 1'b0;
            addr       <= '0;
            words_left <= '0;
            bit_cnt    <= '0;
            lat_cnt    <= '0;
            shreg      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    valid_out <= 1'b0;
                    data_out  <= 1'b0;
                    // After a read, ready rises one cycle after the last data bit.
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (capture) begin
                        ready      <= 1'b0;
                        is_write   <= write_en;
                        is_burst   <= burst;
                        addr       <= ADDR_WIDTH'(address_in);
                        words_left <= '0;
                        lat_cnt    <= '0;
                        if (ADDR_WIDTH == 1) begin
                            bit_cnt <= '0;
                            hold    <= !burst && !write_en;
                            if (burst) begin
                                state <= StBlen;
                            end else if (write_en) begin
                                state <= StWdata;
                            end else begin
                                state <= StRwait;
                            end
                        end else begin
                            bit_cnt <= CNT_W'(1);
                            state   <= StAddr;
                        end
                    end
                end

                StAddr: begin
                    if (capture) begin
                        addr <= addr_shift;
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt <= '0;
                            if (is_burst) begin
                                state <= StBlen;
                            end else if (is_write) begin
                                state <= StWdata;
                            end else begin
                                state <= StRwait;
                                hold  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                StBlen: begin
                    if (capture) begin
                        words_left <= words_shift;
                        if (bit_cnt == BLEN_LAST) begin
                            bit_cnt <= '0;
                            if (is_write) begin
                                state <= StWdata;
                            end else begin
                                state <= StRwait;
                                hold  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                StWdata: begin
                    if (capture) begin
                        shreg <= data_shift;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (words_left == '0) begin
                                state <= StIdle;
                                ready <= 1'b1;
                            end else begin
                                words_left <= words_left - BURST_WIDTH'(1);
                                addr       <= addr_inc;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end

                StRwait: begin
                    if (lat_cnt == LAT_LAST) begin
                        hold    <= 1'b0;
                        shreg   <= mem[addr];
                        bit_cnt <= '0;
                        state   <= StRdata;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end

                StRdata: begin
                    valid_out <= bus_ready;
                    if (bus_ready) begin
                        data_out <= shreg[DATA_WIDTH-1];
                        shreg    <= shreg << 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (words_left == '0) begin
                                state <= StIdle;
                            end else begin
                                // Next burst word follows back-to-back with no extra latency.
                                words_left <= words_left - BURST_WIDTH'(1);
                                addr       <= addr_inc;
                                shreg      <= mem[addr_inc];
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        data_out <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
